// File: rtl/frame_loader.sv
// Double-buffered pixel-to-frame loader feeding a 5x5 classifier; en rises one cycle after the last pixel.
// pix_ready drops once a full frame is waiting for the classifier and returns when that frame is transferred.
module frame_loader #(
  parameter int WIDTH = 25
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_valid,
  input  logic             pix_data,
  input  logic             pix_sof,
  output logic             pix_ready,
  output logic [WIDTH-1:0] frame,
  output logic             en,
  input  logic             cls_ready,
  input  logic [1:0]       cls_out,
  output logic [1:0]       result,
  output logic             result_valid,
  output logic [7:0]       frame_cnt,
  output logic             err
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  localparam logic [0:0] S_FILL = 1'b0;
  localparam logic [0:0] S_FULL = 1'b1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [0:0]       r_fill_st;
  logic [1:0]       r_out_st;
  logic [WIDTH-1:0] r_fill;
  logic [CW-1:0]    r_fill_cnt;
  logic [WIDTH-1:0] r_frame;
  logic             r_cls_ready_d;
  logic [1:0]       r_result;
  logic             r_result_valid;
  logic [7:0]       r_frame_cnt;
  logic             r_err;

  logic w_fill_full;
  logic w_accept;
  logic w_restart;
  logic w_xfer;
  logic w_cls_rise;

  assign w_fill_full = (r_fill_st == S_FULL);
  assign w_accept    = pix_valid && pix_ready;
  assign w_restart   = pix_sof && (r_fill_cnt != '0);
  // GAP is the mandatory en-low cycle, so a waiting frame launches as GAP ends.
  assign w_xfer      = w_fill_full && ((r_out_st == S_IDLE) || (r_out_st == S_GAP));
  assign w_cls_rise  = (r_out_st == S_RUN) && cls_ready && !r_cls_ready_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fill_st  <= S_FILL;
      r_fill     <= '0;
      r_fill_cnt <= '0;
      r_err      <= 1'b0;
    end else if (w_xfer) begin
      r_fill_st  <= S_FILL;
      r_fill_cnt <= '0;
    end else if (w_accept) begin
      if (w_restart) begin
        r_fill     <= WIDTH'(pix_data);
        r_fill_cnt <= CW'(1);
        r_err      <= 1'b1;
      end else begin
        r_fill[r_fill_cnt] <= pix_data;
        if (r_fill_cnt == LAST_IDX) begin
          r_fill_st  <= S_FULL;
          r_fill_cnt <= '0;
        end else begin
          r_fill_cnt <= r_fill_cnt + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_st       <= S_IDLE;
      r_frame        <= '0;
      r_cls_ready_d  <= 1'b0;
      r_result       <= 2'b00;
      r_result_valid <= 1'b0;
      r_frame_cnt    <= 8'd0;
    end else begin
      r_cls_ready_d  <= cls_ready;
      r_result_valid <= 1'b0;
      case (r_out_st)
        S_IDLE: begin
          if (w_xfer) begin
            r_frame  <= r_fill;
            r_out_st <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_cls_rise) begin
            r_result       <= cls_out;
            r_result_valid <= 1'b1;
            r_frame_cnt    <= r_frame_cnt + 8'd1;
            r_out_st       <= S_GAP;
          end
        end
        S_GAP: begin
          if (w_xfer) begin
            r_frame  <= r_fill;
            r_out_st <= S_RUN;
          end else begin
            r_out_st <= S_IDLE;
          end
        end
        default: r_out_st <= S_IDLE;
      endcase
    end
  end

  assign pix_ready    = rst_n && !w_fill_full;
  assign frame        = r_frame;
  assign en           = (r_out_st == S_RUN);
  assign result       = r_result;
  assign result_valid = r_result_valid;
  assign frame_cnt    = r_frame_cnt;
  assign err          = r_err;

endmodule

// File: tb/tb_frame_loader.sv
// Directed bench for frame_loader: fill, double buffering, sof restart, counter wrap, reset abort.
module tb_frame_loader;

  localparam int W = 25;

  logic         clk       = 1'b0;
  logic         rst_n     = 1'b0;
  logic         pix_valid = 1'b0;
  logic         pix_data  = 1'b0;
  logic         pix_sof   = 1'b0;
  logic         cls_ready = 1'b0;
  logic [1:0]   cls_out   = 2'b00;
  logic         pix_ready;
  logic [W-1:0] frame;
  logic         en;
  logic [1:0]   result;
  logic         result_valid;
  logic [7:0]   frame_cnt;
  logic         err;

  int n_checks = 0;
  int n_err    = 0;
  int rv_cnt   = 0;

  frame_loader #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pix_valid    (pix_valid),
    .pix_data     (pix_data),
    .pix_sof      (pix_sof),
    .pix_ready    (pix_ready),
    .frame        (frame),
    .en           (en),
    .cls_ready    (cls_ready),
    .cls_out      (cls_out),
    .result       (result),
    .result_valid (result_valid),
    .frame_cnt    (frame_cnt),
    .err          (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (result_valid === 1'b1) rv_cnt++;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the pixel was accepted.
  task automatic push(input logic d, input logic sof);
    int n;
    n = 0;
    pix_valid = 1'b1;
    pix_data  = d;
    pix_sof   = sof;
    #1;
    while (!pix_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!pix_ready) check("push_timeout", 32'(pix_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  task automatic push_frame(input logic [W-1:0] p);
    for (int i = 0; i < W; i++) push(p[i], 1'b0);
  endtask

  task automatic wait_en();
    int n;
    n = 0;
    while (!en && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!en) check("en_timeout", 32'(en), 32'd1);
  endtask

  // One-cycle cls_ready pulse from RUN; returns at the negedge where result_valid is high.
  task automatic classify(input logic [1:0] code);
    cls_out   = code;
    cls_ready = 1'b1;
    @(negedge clk);
    cls_ready = 1'b0;
  endtask

  task automatic run_frame(input logic [W-1:0] p, input logic [1:0] code);
    push_frame(p);
    wait_en();
    classify(code);
    @(negedge clk);
  endtask

  logic [W-1:0] p1, pa, pb, pc, pe, pf;

  initial begin
    p1 = 25'h1101011;
    pa = 25'h0AAAAAA;
    pb = 25'h13C3C3C;
    pc = 25'h1555555;
    pe = 25'h0ABCDEF;
    pf = 25'h1000000;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_pix_ready", 32'(pix_ready), 32'd0);
    check("rst_en", 32'(en), 32'd0);
    check("rst_frame", 32'(frame), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_rv", 32'(result_valid), 32'd0);
    check("rst_fcnt", 32'(frame_cnt), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    #1;
    check("rdy_after_rst", 32'(pix_ready), 32'd1);

    // First frame, pixel 0 flagged with sof at fill_cnt=0 (normal start)
    push(p1[0], 1'b1);
    for (int i = 1; i < W; i++) push(p1[i], 1'b0);
    check("t1_full_rdy", 32'(pix_ready), 32'd0);
    check("t1_en_pre", 32'(en), 32'd0);
    @(negedge clk);
    check("t1_en", 32'(en), 32'd1);
    check("t1_frame", 32'(frame), 32'h1101011);
    check("t1_rdy_run", 32'(pix_ready), 32'd1);
    check("t1_err", 32'(err), 32'd0);
    // cls_ready held two cycles
    cls_out   = 2'b11;
    cls_ready = 1'b1;
    @(negedge clk);
    check("t1_result", 32'(result), 32'd3);
    check("t1_rv", 32'(result_valid), 32'd1);
    check("t1_en_low", 32'(en), 32'd0);
    check("t1_fcnt", 32'(frame_cnt), 32'd1);
    check("t1_frame_hold", 32'(frame), 32'h1101011);
    @(negedge clk);
    check("t1_rv_once", 32'(result_valid), 32'd0);
    check("t1_en_idle", 32'(en), 32'd0);
    cls_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("t1_rv_cnt", 32'(rv_cnt), 32'd1);
    check("t1_fcnt_hold", 32'(frame_cnt), 32'd1);

    // Second frame streamed while the first is classified
    push_frame(pa);
    wait_en();
    check("t2_frame_a", 32'(frame), 32'(pa));
    push_frame(pb);
    check("t2_rdy_full", 32'(pix_ready), 32'd0);
    check("t2_en_run", 32'(en), 32'd1);
    check("t2_frame_stable", 32'(frame), 32'(pa));
    repeat (2) @(negedge clk);
    check("t2_rdy_still", 32'(pix_ready), 32'd0);
    classify(2'b10);
    check("t2_gap_en", 32'(en), 32'd0);
    check("t2_gap_rv", 32'(result_valid), 32'd1);
    check("t2_result", 32'(result), 32'd2);
    check("t2_gap_frame", 32'(frame), 32'(pa));
    @(negedge clk);
    check("t2_en_back", 32'(en), 32'd1);
    check("t2_frame_b", 32'(frame), 32'(pb));
    check("t2_rdy_back", 32'(pix_ready), 32'd1);
    check("t2_fcnt", 32'(frame_cnt), 32'd2);

    // Finish frame B, then sof mid-frame restart
    classify(2'b01);
    check("t3_result_b", 32'(result), 32'd1);
    check("t3_fcnt", 32'(frame_cnt), 32'd3);
    @(negedge clk);
    for (int i = 0; i < 10; i++) push(1'b1, 1'b0);
    check("t3_err_pre", 32'(err), 32'd0);
    push(pc[0], 1'b1);
    check("t3_err", 32'(err), 32'd1);
    for (int i = 1; i < W - 1; i++) push(pc[i], 1'b0);
    check("t3_rdy_23", 32'(pix_ready), 32'd1);
    check("t3_en_23", 32'(en), 32'd0);
    push(pc[W-1], 1'b0);
    check("t3_rdy_24", 32'(pix_ready), 32'd0);
    @(negedge clk);
    check("t3_en", 32'(en), 32'd1);
    check("t3_frame", 32'(frame), 32'(pc));
    classify(2'b10);
    check("t3_result", 32'(result), 32'd2);
    check("t3_fcnt2", 32'(frame_cnt), 32'd4);
    @(negedge clk);

    // Counter wrap
    for (int i = 0; i < 251; i++) run_frame(25'(i * 40503 + 7), 2'((i % 3) + 1));
    check("t4_fcnt_255", 32'(frame_cnt), 32'd255);
    run_frame(pc, 2'b01);
    check("t4_fcnt_wrap", 32'(frame_cnt), 32'd0);
    run_frame(pe, 2'b11);
    check("t4_fcnt_1", 32'(frame_cnt), 32'd1);
    check("t4_result", 32'(result), 32'd3);
    check("t4_err_sticky", 32'(err), 32'd1);

    // Reset during RUN with a partial fill in progress
    push_frame(pa);
    wait_en();
    for (int i = 0; i < 5; i++) push(1'b1, 1'b0);
    rst_n     = 1'b0;
    cls_out   = 2'b11;
    cls_ready = 1'b1;
    #1;
    check("t5_rdy_in_rst", 32'(pix_ready), 32'd0);
    @(negedge clk);
    check("t5_en", 32'(en), 32'd0);
    check("t5_frame", 32'(frame), 32'd0);
    check("t5_result", 32'(result), 32'd0);
    check("t5_fcnt", 32'(frame_cnt), 32'd0);
    check("t5_err", 32'(err), 32'd0);
    check("t5_rv", 32'(result_valid), 32'd0);
    rst_n     = 1'b1;
    cls_ready = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 20; i++) push(pf[i], 1'b0);
    check("t5_rdy_20", 32'(pix_ready), 32'd1);
    for (int i = 20; i < W; i++) push(pf[i], 1'b0);
    wait_en();
    check("t5_frame_new", 32'(frame), 32'(pf));
    repeat (2) @(negedge clk);
    check("t5_rv_total", 32'(rv_cnt), 32'd257);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
